// File: rtl/uart_tx_mmio_pkg.sv
// Shared register map, status layout and FSM encodings for the memory-mapped UART transmitter.
package uart_tx_mmio_pkg;

  localparam int unsigned UartDivW = 16;
  typedef logic [UartDivW-1:0] uart_div_t;

  // Byte offsets within the UART window; bits [1:0] of the address are ignored.
  localparam logic [3:0] UartTxData = 4'h0;
  localparam logic [3:0] UartStatus = 4'h4;
  localparam logic [3:0] UartBaud   = 4'h8;

  localparam int unsigned StFull     = 0;
  localparam int unsigned StEmpty    = 1;
  localparam int unsigned StBusy     = 2;
  localparam int unsigned StOvf      = 3;
  localparam int unsigned StIrqEn    = 4;
  localparam int unsigned StCountLsb = 8;
  localparam int unsigned StCountW   = 3;

  typedef enum logic [1:0] {
    UartIdle  = 2'd0,
    UartStart = 2'd1,
    UartData  = 2'd2,
    UartStop  = 2'd3
  } uart_state_e;

  // Last cycle index of one bit period: max(div,1) - 1.
  function automatic uart_div_t bit_last(input uart_div_t div);
    return (div == '0) ? '0 : div - 16'd1;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous byte FIFO; a push while full is accepted only if a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned CountW = AddrW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AddrW-1:0] wr_ptr;
  logic [AddrW-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CountW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AddrW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AddrW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CountW'(1);
        2'b01:   count <= count - CountW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, transmit FIFO and serialiser FSM.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter uart_div_t   DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]        word_addr;
  logic              wr_en;
  logic              push_req;
  logic              pop;
  logic [7:0]        fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CountW-1:0] fifo_count;

  uart_state_e state;
  uart_div_t   baud_div;
  uart_div_t   cyc_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        overflow;
  logic        enable_irq;
  logic        bit_done;
  logic        unused_ok;

  assign unused_ok = ^{addr_i[1:0], sel_i[3:2], data_i[31:16]};

  assign word_addr = {addr_i[3:2], 2'b00};
  assign wr_en     = cs_i & we_i;
  assign push_req  = wr_en & sel_i[0] & (word_addr == UartTxData);

  // Compare with >= so a shorter divisor written mid-bit ends the bit on the next edge.
  assign bit_done  = (cyc_cnt >= bit_last(baud_div));
  assign pop       = ~fifo_empty &
                     ((state == UartIdle) | ((state == UartStop) & bit_done));

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .wdata (data_i[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Configuration, sticky overflow and interrupt registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_div   <= DEFAULT_DIV;
      overflow   <= 1'b0;
      enable_irq <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      irq_o <= enable_irq & fifo_empty;
      if (wr_en && word_addr == UartStatus && sel_i[0]) begin
        enable_irq <= data_i[StIrqEn];
        if (data_i[StOvf]) overflow <= 1'b0;
      end
      if (wr_en && word_addr == UartBaud) begin
        if (sel_i[0]) baud_div[7:0]  <= data_i[7:0];
        if (sel_i[1]) baud_div[15:8] <= data_i[15:8];
      end
      if (push_req && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  // Serialiser: start bit, 8 data bits LSB first, stop bit; back-to-back frames out of STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= UartIdle;
      cyc_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_o    <= 1'b1;
    end else begin
      if (state == UartIdle || bit_done) cyc_cnt <= '0;
      else                               cyc_cnt <= cyc_cnt + 16'd1;

      case (state)
        UartIdle: begin
          if (pop) begin
            shift   <= fifo_rdata;
            bit_idx <= '0;
            tx_o    <= 1'b0;
            state   <= UartStart;
          end
        end
        UartStart: begin
          if (bit_done) begin
            tx_o    <= shift[0];
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= '0;
            state   <= UartData;
          end
        end
        UartData: begin
          if (bit_done) begin
            if (bit_idx == 3'd7) begin
              tx_o  <= 1'b1;
              state <= UartStop;
            end else begin
              tx_o    <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        UartStop: begin
          if (bit_done) begin
            if (pop) begin
              shift   <= fifo_rdata;
              bit_idx <= '0;
              tx_o    <= 1'b0;
              state   <= UartStart;
            end else begin
              state <= UartIdle;
            end
          end
        end
        default: begin
          tx_o  <= 1'b1;
          state <= UartIdle;
        end
      endcase
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    data_o = '0;
    case (word_addr)
      UartStatus: begin
        data_o[StFull]                      = fifo_full;
        data_o[StEmpty]                     = fifo_empty;
        data_o[StBusy]                      = (state != UartIdle);
        data_o[StOvf]                       = overflow;
        data_o[StIrqEn]                     = enable_irq;
        data_o[StCountLsb +: StCountW]      = StCountW'(fifo_count);
      end
      UartBaud: begin
        data_o[15:0] = baud_div;
      end
      default: begin
        data_o = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio: frames, FIFO overflow, baud change, reset and irq.
module tb_uart_tx_mmio;

  logic        clk;
  logic        rst;
  logic        cs_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic [3:0]  addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        tx_o;
  logic        irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_mmio #(
    .FIFO_DEPTH  (4),
    .DEFAULT_DIV (16'd868)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .cs_i   (cs_i),
    .we_i   (we_i),
    .sel_i  (sel_i),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .tx_o   (tx_o),
    .irq_o  (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    cs_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d; sel_i = s;
    tick();
    cs_i = 1'b0; we_i = 1'b0; addr_i = 4'h0; data_i = 32'h0; sel_i = 4'h0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    cs_i = 1'b1; addr_i = a;
    #1;
    d = data_o;
    cs_i = 1'b0; addr_i = 4'h0;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%020h expected 0x%020h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [79:0] seq;
    logic [79:0] exp;
    logic [9:0]  fr_a;
    logic [9:0]  fr_b;

    rst = 1'b1; cs_i = 1'b0; we_i = 1'b0; sel_i = 4'h0; addr_i = 4'h0; data_i = 32'h0;
    reset_dut();

    // Reset state
    chk_bit("rst_tx", tx_o, 1'b1);
    chk_bit("rst_irq", irq_o, 1'b0);
    rd(4'h4, r); chk_word("rst_status", r, 32'h0000_0002);
    rd(4'h8, r); chk_word("rst_baud", r, 32'd868);
    rd(4'hC, r); chk_word("rsvd_read", r, 32'h0);
    rd(4'h0, r); chk_word("txdata_read", r, 32'h0);

    // Basic frame: 0xA5 at 4 clocks per bit
    wr(4'h8, 32'h0000_0004, 4'b0011);
    rd(4'h8, r); chk_word("t1_baud", r, 32'h4);
    wr(4'h0, 32'h0000_00A5, 4'b0001);
    chk_bit("t1_idle_after_push", tx_o, 1'b1);
    rd(4'h4, r); chk_word("t1_status_queued", r, 32'h0000_0100);
    fr_a = 10'b1101001010;
    seq = '0; exp = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seq[i] = tx_o;
      exp[i] = fr_a[i/4];
      if (i == 5) begin
        rd(4'h4, r); chk_word("t1_status_busy", r, 32'h0000_0006);
      end
    end
    chk_vec("t1_frame", seq, exp);
    tick();
    rd(4'h4, r); chk_word("t1_status_done", r, 32'h0000_0002);
    chk_bit("t1_tx_idle", tx_o, 1'b1);

    // Overflow: 0x01 popped, 0x02..0x05 queued, 0x06 dropped
    wr(4'h8, 32'd100, 4'b0011);
    for (int k = 1; k <= 6; k++) wr(4'h0, 32'(k), 4'b0001);
    rd(4'h4, r); chk_word("t2_status_ovf", r, 32'h0000_040D);
    chk_bit("t2_start_bit", tx_o, 1'b0);
    tick();
    rd(4'h4, r); chk_word("t2_ovf_sticky", r, 32'h0000_040D);
    wr(4'h4, 32'h0000_0008, 4'b0001);
    rd(4'h4, r); chk_word("t2_ovf_cleared", r, 32'h0000_0405);
    reset_dut();

    // Back-to-back frames 0x00 then 0xFF at 2 clocks per bit
    wr(4'h8, 32'd2, 4'b0011);
    wr(4'h0, 32'h0000_0000, 4'b0001);
    chk_bit("t3_idle_after_push", tx_o, 1'b1);
    wr(4'h0, 32'h0000_00FF, 4'b0001);
    fr_a = 10'b1000000000;
    fr_b = 10'b1111111110;
    seq = '0; exp = '0;
    seq[0] = tx_o;
    for (int i = 1; i < 40; i++) begin
      tick();
      seq[i] = tx_o;
    end
    for (int i = 0; i < 40; i++) exp[i] = (i < 20) ? fr_a[i/2] : fr_b[(i-20)/2];
    chk_vec("t3_frames", seq, exp);
    tick();
    rd(4'h4, r); chk_word("t3_status_done", r, 32'h0000_0002);

    // Baud change mid start bit: 10 -> 3 with the cycle counter at 6
    wr(4'h8, 32'd10, 4'b0011);
    wr(4'h0, 32'h0000_0001, 4'b0001);
    repeat (7) tick();
    chk_bit("t4_start_before", tx_o, 1'b0);
    wr(4'h8, 32'd3, 4'b0011);
    chk_bit("t4_start_held", tx_o, 1'b0);
    fr_a = 10'b1000000010;
    seq = '0; exp = '0;
    for (int i = 0; i < 27; i++) begin
      tick();
      seq[i] = tx_o;
      exp[i] = fr_a[1 + i/3];
    end
    chk_vec("t4_bits", seq, exp);
    tick();
    rd(4'h4, r); chk_word("t4_status_done", r, 32'h0000_0002);

    // Asynchronous reset during DATA
    wr(4'h8, 32'd4, 4'b0011);
    wr(4'h0, 32'h0000_0000, 4'b0001);
    repeat (8) tick();
    chk_bit("t5_tx_data_low", tx_o, 1'b0);
    rd(4'h4, r); chk_word("t5_status_busy", r, 32'h0000_0006);
    #2 rst = 1'b1;
    #1;
    chk_bit("t5_tx_async", tx_o, 1'b1);
    rd(4'h4, r); chk_word("t5_status_in_rst", r, 32'h0000_0002);
    @(posedge clk);
    #1 rst = 1'b0;
    rd(4'h8, r); chk_word("t5_baud_default", r, 32'd868);
    rd(4'h4, r); chk_word("t5_status_after", r, 32'h0000_0002);
    repeat (3) tick();
    chk_bit("t5_tx_stays_idle", tx_o, 1'b1);

    // Interrupt enable, sel masking and cs masking
    wr(4'h4, 32'h0000_0010, 4'b0001);
    chk_bit("t6_irq_lag", irq_o, 1'b0);
    tick();
    chk_bit("t6_irq_set", irq_o, 1'b1);
    wr(4'h0, 32'h0000_0055, 4'b0010);
    chk_bit("t6_irq_sel_mask", irq_o, 1'b1);
    rd(4'h4, r); chk_word("t6_status_sel_mask", r, 32'h0000_0012);
    cs_i = 1'b0; we_i = 1'b1; addr_i = 4'h0; sel_i = 4'b0001; data_i = 32'h66;
    tick();
    we_i = 1'b0; sel_i = 4'h0; data_i = 32'h0;
    rd(4'h4, r); chk_word("t6_status_cs_mask", r, 32'h0000_0012);
    chk_bit("t6_tx_idle", tx_o, 1'b1);
    wr(4'h0, 32'h0000_003C, 4'b0001);
    chk_bit("t6_irq_before_drop", irq_o, 1'b1);
    tick();
    chk_bit("t6_irq_drop", irq_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the core's data-memory bus, beside data_ram. It consumes the same we/sel/addr/data store traffic the core issues.
- The SoC address decoder routes a store to this block when the address falls in the UART window. The block queues the bytes in a small FIFO and serialises each one as an 8N1 frame on tx_o.
- Loads from the window return status and configuration data.

Parameters:
- FIFO_DEPTH, 4, byte entries in the transmit FIFO; must be a power of two, at least 2.
- DEFAULT_DIV, 16'd868, reset value of BAUD_DIV in clocks per bit.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cs_i  in  1  window select from the SoC decoder; the block ignores we_i when cs_i=0.
- we_i  in  1  write enable, same timing as data_ram we_i.
- sel_i  in  4  byte lane enables; lane 0 = data_i[7:0].
- addr_i  in  4  byte offset within the window; bits [1:0] are ignored.
- data_i  in  32  write data.
- data_o  out  32  read data, combinational from addr_i and registers.
- tx_o  out  1  serial output, registered, idle high.
- irq_o  out  1  level interrupt, high when the FIFO is empty and enable_irq=1.

Behaviour:
- Register map (offsets):
  - 0x0 TXDATA: write with sel_i[0]=1 pushes data_i[7:0]; reads return 0.
  - 0x4 STATUS: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bit4 enable_irq, bits[10:8] count; all other bits read 0. Writing bit3=1 clears overflow. Writing with sel_i[0] loads enable_irq from data_i[4].
  - 0x8 BAUD_DIV: bits[15:0], written per lane with sel_i[1:0]; upper bits read 0.
  - 0xC: reserved; reads 0, writes ignored.
- Reset values:
  - tx_o=1, irq_o=0, FSM=IDLE, FIFO empty, overflow=0, enable_irq=0, BAUD_DIV=DEFAULT_DIV, bit counters=0.
  - Reset is asynchronous: a frame in progress is abandoned and tx_o returns high immediately.
- FIFO push: cs_i & we_i & sel_i[0] at offset 0x0.
  - Accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty at a clock edge, pop the byte into the shift register, set tx_o<=0 and go to START.
  - Each bit lasts N = max(BAUD_DIV,1) cycles. The bit counter advances when the cycle counter reaches N-1 (compare with >=).
  - A BAUD_DIV write mid-bit takes effect immediately. If the counter is already at or above the new N-1, the bit ends on the next edge.
  - START -> DATA: tx_o <= shift[0]. The 8 data bits go out LSB first.
  - After the 8th bit: tx_o<=1, go to STOP.
  - End of STOP: if the FIFO is non-empty, pop the next byte, tx_o<=0, go to START (back-to-back frames with no idle gap). Otherwise go to IDLE.
  - Frame length is 10*N cycles.
- Latency: push at edge E0 -> tx_o falls after E1 when the FSM was IDLE.
- irq_o is registered: irq_o <= enable_irq & empty.
- Read data is combinational with zero wait states, matching data_ram.

Decomposition:
- Add to define.v:
  - UART register offsets: UartTxData, UartStatus, UartBaud.
  - STATUS bit positions.
  - FSM state encodings: 2-bit UartIdle, UartStart, UartData, UartStop.
  - UartDivBus 15:0.
- One sub-module, uart_sync_fifo: parameterised depth and width 8; push/pop/full/empty/count outputs; same clk/rst.
- The register decode and FSM stay in uart_tx_mmio.

Test Plan:
- Basic frame: BAUD_DIV=4, write 0xA5 to 0x0 -> tx_o is 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; total 40 cycles; STATUS.busy drops after that.
- Overflow: FIFO_DEPTH=4, BAUD_DIV=100, six writes 0x01..0x06 on consecutive cycles -> 0x01 popped at once, 0x02..0x05 queued, 0x06 dropped. STATUS reads full=1, overflow=1, count=4. Writing STATUS bit3=1 clears overflow.
- Back-to-back frames: two bytes 0x00 and 0xFF queued, BAUD_DIV=2 -> the second start bit follows the first stop bit with no gap; 40 cycles total.
- Baud change mid-bit: BAUD_DIV=10, cycle counter at 6, write BAUD_DIV=3 -> the current bit ends on the next edge; subsequent bits are 3 cycles each.
- Reset mid-frame: assert rst during DATA -> tx_o=1 and busy=0 asynchronously; FIFO empty and BAUD_DIV=DEFAULT_DIV after release.
- Interrupt and sel masking: enable_irq=1 with FIFO empty -> irq_o=1 one cycle later. Write to TXDATA with sel_i=4'b0010 -> no push; irq_o stays 1.
